// File: rtl/perf_cnt_pkg.sv
// ============================================================================
// Module   : perf_cnt_pkg
// Purpose  : CSR addresses and inhibit/status bit indices for perf_counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package perf_cnt_pkg;

    localparam logic [11:0] c_CSR_CYCLE          = 12'hC00;
    localparam logic [11:0] c_CSR_CYCLEH         = 12'hC80;
    localparam logic [11:0] c_CSR_MCYCLE         = 12'hB00;
    localparam logic [11:0] c_CSR_MCYCLEH        = 12'hB80;
    localparam logic [11:0] c_CSR_MCOUNTINHIBIT  = 12'h320;
    localparam logic [11:0] c_CSR_MHPMEVENT3     = 12'h323;
    localparam logic [11:0] c_CSR_MCNTOVF        = 12'h7C0;

    localparam int c_BIT_CY   = 0;
    localparam int c_BIT_IR   = 2;
    localparam int c_BIT_HPM0 = 3;

    // Counter slot 0 = cycle, 1 = instret, 2+i = hpm i. The returned index is
    // both the CSR address offset and the inhibit/status bit position.
    function automatic int cnt_index(input int idx);
        if (idx == 0)
            return c_BIT_CY;
        else if (idx == 1)
            return c_BIT_IR;
        else
            return c_BIT_HPM0 + idx - 2;
    endfunction

endpackage

`default_nettype wire

// File: rtl/perf_cnt_slice.sv
// ============================================================================
// Module   : perf_cnt_slice
// Purpose  : One wrapping counter with inhibit, split 32-bit half writes and
//            a wrap flag. Bits at or above WIDTH are held at zero.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module perf_cnt_slice #(
    parameter int WIDTH = 64
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic        inc,
    input  logic        inhibit,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wdata,
    output logic [63:0] value,
    output logic        wrap
);

    localparam logic [63:0] c_MASK = (WIDTH >= 64) ? {64{1'b1}}
                                                    : ((64'd1 << WIDTH) - 64'd1);

    logic [63:0] r_cnt;
    logic [63:0] w_wr_val;
    logic        w_wr;
    logic        w_inc_en;

    assign w_wr     = wr_lo | wr_hi;
    assign w_inc_en = inc & ~inhibit;
    assign w_wr_val = {(wr_hi ? wdata : r_cnt[63:32]),
                       (wr_lo ? wdata : r_cnt[31:0])} & c_MASK;

    // A write wins over a same-cycle increment.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset)
            r_cnt <= '0;
        else if (w_wr)
            r_cnt <= w_wr_val;
        else if (w_inc_en)
            r_cnt <= (r_cnt + 64'd1) & c_MASK;
    end

    assign value = r_cnt;
    assign wrap  = w_inc_en & ~w_wr & (r_cnt == c_MASK);

endmodule

`default_nettype wire

// File: rtl/perf_counters.sv
// ============================================================================
// Module   : perf_counters
// Purpose  : cycle/instret/hpm counters behind a CSR read/write port.
//            Optional overflow status + interrupt: define PERF_CNT_OVF_IRQ_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module perf_counters
    import perf_cnt_pkg::*;
#(
    parameter int NUM_HPM    = 4,
    parameter int CNT_WIDTH  = 64,
    parameter int NUM_EVENTS = 8
) (
    input  logic                  clk,
    input  logic                  n_reset,
    input  logic                  ev_retire,
    input  logic [NUM_EVENTS-1:0] ev_vec,
    input  logic                  csr_re,
    input  logic                  csr_we,
    input  logic [11:0]           csr_addr,
    input  logic [31:0]           csr_wdata,
    output logic [31:0]           csr_rdata,
    output logic                  csr_hit,
    output logic                  ovf_irq
);

    localparam int          c_NUM_CNT   = 2 + NUM_HPM;
    localparam int          c_HPM_SLOTS = (NUM_HPM > 0) ? NUM_HPM : 1;
    localparam logic [31:0] c_INH_MASK  = 32'h0000_0005
                                        | (((32'd1 << NUM_HPM) - 32'd1) << c_BIT_HPM0);

    logic [31:0]          r_mcountinhibit;
    logic [31:0]          r_mhpmevent [c_HPM_SLOTS];
    logic [63:0]          w_cnt_val   [c_NUM_CNT];
    logic [c_NUM_CNT-1:0] w_inc;
    logic [c_NUM_CNT-1:0] w_wrap;
    logic [31:0]          w_wrap_bits;
    logic [31:0]          w_rdata;
    logic                 w_hit;

    // An hpm counter only counts for a selector in 1..NUM_EVENTS.
    always_comb begin
        w_inc    = '0;
        w_inc[0] = 1'b1;
        w_inc[1] = ev_retire;
        for (int i = 0; i < NUM_HPM; i++) begin
            for (int k = 1; k <= NUM_EVENTS; k++) begin
                if (r_mhpmevent[i] == 32'(k) && ev_vec[k-1])
                    w_inc[2+i] = 1'b1;
            end
        end
    end

    for (genvar j = 0; j < c_NUM_CNT; j++) begin : g_cnt
        localparam int c_IDX = cnt_index(j);

        perf_cnt_slice #(
            .WIDTH (CNT_WIDTH)
        ) u_slice (
            .clk     (clk),
            .n_reset (n_reset),
            .inc     (w_inc[j]),
            .inhibit (r_mcountinhibit[c_IDX]),
            .wr_lo   (csr_we && (csr_addr == c_CSR_MCYCLE  + 12'(c_IDX))),
            .wr_hi   (csr_we && (csr_addr == c_CSR_MCYCLEH + 12'(c_IDX))),
            .wdata   (csr_wdata),
            .value   (w_cnt_val[j]),
            .wrap    (w_wrap[j])
        );
    end

    always_comb begin
        w_wrap_bits = '0;
        for (int j = 0; j < c_NUM_CNT; j++)
            w_wrap_bits[cnt_index(j)] = w_wrap[j];
    end

`ifdef PERF_CNT_OVF_IRQ_EN
    logic [31:0] r_ovf_status;
    logic [31:0] w_ovf_clr;

    assign w_ovf_clr = (csr_we && csr_addr == c_CSR_MCNTOVF) ? csr_wdata : 32'd0;

    // Setting is applied after clearing so a wrap in the clear cycle survives.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset)
            r_ovf_status <= '0;
        else
            r_ovf_status <= ((r_ovf_status & ~w_ovf_clr) | w_wrap_bits) & c_INH_MASK;
    end

    assign ovf_irq = |r_ovf_status;
`else
    logic w_unused_wrap;
    assign w_unused_wrap = ^w_wrap_bits;
    assign ovf_irq       = 1'b0;
`endif

    always_comb begin
        w_rdata = '0;
        w_hit   = 1'b0;
        for (int j = 0; j < c_NUM_CNT; j++) begin
            if (csr_addr == c_CSR_CYCLE  + 12'(cnt_index(j)) ||
                csr_addr == c_CSR_MCYCLE + 12'(cnt_index(j))) begin
                w_hit   = 1'b1;
                w_rdata = w_cnt_val[j][31:0];
            end
            if (csr_addr == c_CSR_CYCLEH  + 12'(cnt_index(j)) ||
                csr_addr == c_CSR_MCYCLEH + 12'(cnt_index(j))) begin
                w_hit   = 1'b1;
                w_rdata = w_cnt_val[j][63:32];
            end
        end
        for (int i = 0; i < NUM_HPM; i++) begin
            if (csr_addr == c_CSR_MHPMEVENT3 + 12'(i)) begin
                w_hit   = 1'b1;
                w_rdata = r_mhpmevent[i];
            end
        end
        if (csr_addr == c_CSR_MCOUNTINHIBIT) begin
            w_hit   = 1'b1;
            w_rdata = r_mcountinhibit;
        end
`ifdef PERF_CNT_OVF_IRQ_EN
        if (csr_addr == c_CSR_MCNTOVF) begin
            w_hit   = 1'b1;
            w_rdata = r_ovf_status;
        end
`endif
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            csr_rdata       <= '0;
            csr_hit         <= 1'b0;
            r_mcountinhibit <= '0;
            for (int i = 0; i < c_HPM_SLOTS; i++)
                r_mhpmevent[i] <= '0;
        end else begin
            csr_hit   <= csr_re & w_hit;
            csr_rdata <= (csr_re && w_hit) ? w_rdata : 32'd0;
            if (csr_we && csr_addr == c_CSR_MCOUNTINHIBIT)
                r_mcountinhibit <= csr_wdata & c_INH_MASK;
            for (int i = 0; i < NUM_HPM; i++) begin
                if (csr_we && csr_addr == c_CSR_MHPMEVENT3 + 12'(i))
                    r_mhpmevent[i] <= csr_wdata;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_perf_counters.sv
// ============================================================================
// Module   : tb_perf_counters
// Purpose  : Directed scoreboard bench for perf_counters (CNT_WIDTH = 32).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_perf_counters;

    localparam int NUM_HPM    = 4;
    localparam int CNT_WIDTH  = 32;
    localparam int NUM_EVENTS = 8;
`ifdef PERF_CNT_OVF_IRQ_EN
    localparam logic c_OVF = 1'b1;
`else
    localparam logic c_OVF = 1'b0;
`endif

    logic                  clk       = 1'b0;
    logic                  n_reset   = 1'b0;
    logic                  ev_retire = 1'b0;
    logic [NUM_EVENTS-1:0] ev_vec    = '0;
    logic                  csr_re    = 1'b0;
    logic                  csr_we    = 1'b0;
    logic [11:0]           csr_addr  = '0;
    logic [31:0]           csr_wdata = '0;
    logic [31:0]           csr_rdata;
    logic                  csr_hit;
    logic                  ovf_irq;

    typedef struct packed {
        logic [11:0] addr;
        logic [31:0] data;
        logic        hit;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    logic rd_pending = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    perf_counters #(
        .NUM_HPM    (NUM_HPM),
        .CNT_WIDTH  (CNT_WIDTH),
        .NUM_EVENTS (NUM_EVENTS)
    ) dut (
        .clk       (clk),
        .n_reset   (n_reset),
        .ev_retire (ev_retire),
        .ev_vec    (ev_vec),
        .csr_re    (csr_re),
        .csr_we    (csr_we),
        .csr_addr  (csr_addr),
        .csr_wdata (csr_wdata),
        .csr_rdata (csr_rdata),
        .csr_hit   (csr_hit),
        .ovf_irq   (ovf_irq)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        csr_we    = 1'b1;
        csr_addr  = a;
        csr_wdata = d;
        tick();
        csr_we    = 1'b0;
    endtask

    task automatic rd(input logic [11:0] a, input logic [31:0] d, input logic h);
        csr_re   = 1'b1;
        csr_addr = a;
        exp_q.push_back('{addr: a, data: d, hit: h});
        tick();
        csr_re   = 1'b0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: a read accepted on one edge is presented until the next edge.
    always @(posedge clk) rd_pending <= csr_re & n_reset;

    always @(negedge clk) begin
        if (rd_pending) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rd_unexpected: got data 0x%08h hit %0b with nothing expected",
                         csr_rdata, csr_hit);
            end else begin
                mon_e = exp_q.pop_front();
                if (csr_rdata !== mon_e.data || csr_hit !== mon_e.hit) begin
                    errors++;
                    $display("FAIL rd_%03h: got data 0x%08h hit %0b expected data 0x%08h hit %0b",
                             mon_e.addr, csr_rdata, csr_hit, mon_e.data, mon_e.hit);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pat [5];
        pat[0] = 8'h03; pat[1] = 8'h03; pat[2] = 8'h03; pat[3] = 8'h03; pat[4] = 8'h02;

        // Reset state
        #12;
        check("rst_rdata", csr_rdata, 32'd0);
        check("rst_ovf", {31'd0, ovf_irq}, 32'd0);
        #10 n_reset = 1'b1;
        rd(12'hC02, 32'd0, 1'b1);
        rd(12'h320, 32'd0, 1'b1);

        // Three retires
        repeat (3) begin
            ev_retire = 1'b1; tick();
            ev_retire = 1'b0; tick();
        end
        rd(12'hC02, 32'd3, 1'b1);
        rd(12'hC82, 32'd0, 1'b1);

        // Write beats increment; read sees pre-edge value
        ev_retire = 1'b1;
        wr(12'hB02, 32'h100);
        rd(12'hC02, 32'h100, 1'b1);
        ev_retire = 1'b0;
        rd(12'hC02, 32'h101, 1'b1);

        // Event selection
        wr(12'h323, 32'd2);
        rd(12'h323, 32'd2, 1'b1);
        for (int i = 0; i < 5; i++) begin
            ev_vec = pat[i]; tick();
        end
        ev_vec = '0;
        rd(12'hC03, 32'd5, 1'b1);
        wr(12'h323, 32'h10);
        ev_vec = 8'hFF; tick(); tick(); tick();
        ev_vec = '0;
        rd(12'hC03, 32'd5, 1'b1);
        rd(12'hC83, 32'd0, 1'b1);
        wr(12'h324, 32'd8);
        ev_vec = 8'h80; tick(); tick();
        ev_vec = '0;
        rd(12'hC04, 32'd2, 1'b1);

        // Unmapped addresses
        rd(12'hC07, 32'd0, 1'b0);
        rd(12'h321, 32'd0, 1'b0);

        // Inhibit register masking
        wr(12'h320, 32'hFFFF_FFFF);
        rd(12'h320, 32'h7D, 1'b1);
        wr(12'h320, 32'd0);

        // Cycle inhibit
        wr(12'hB00, 32'h1000);
        wr(12'h320, 32'd1);
        rd(12'hC00, 32'h1001, 1'b1);
        repeat (10) tick();
        rd(12'hC00, 32'h1001, 1'b1);
        wr(12'h320, 32'd0);
        rd(12'hC00, 32'h1001, 1'b1);
        rd(12'hC00, 32'h1002, 1'b1);
        tick(); tick();
        rd(12'hC00, 32'h1005, 1'b1);

        // 32-bit wrap, high half write ignored
        wr(12'hB80, 32'd0);
        wr(12'hB00, 32'hFFFF_FFFF);
        tick();
        rd(12'hC00, 32'd0, 1'b1);
        rd(12'hC80, 32'd0, 1'b1);
        check("ovf_after_wrap", {31'd0, ovf_irq}, {31'd0, c_OVF});
        rd(12'h7C0, {31'd0, c_OVF}, c_OVF);
        wr(12'h7C0, 32'd1);
        check("ovf_cleared", {31'd0, ovf_irq}, 32'd0);

        // Wrap coinciding with clear keeps the status bit
        wr(12'hB00, 32'hFFFF_FFFE);
        tick();
        wr(12'h7C0, 32'd1);
        check("ovf_wrap_and_clear", {31'd0, ovf_irq}, {31'd0, c_OVF});

        // Asynchronous reset mid-count and mid-write
        rd(12'hC02, 32'h101, 1'b1);
        @(negedge clk);
        #1;
        csr_we = 1'b1; csr_addr = 12'hB02; csr_wdata = 32'h55;
        #1 n_reset = 1'b0;
        #1;
        check("async_rst_rdata", csr_rdata, 32'd0);
        check("async_rst_ovf", {31'd0, ovf_irq}, 32'd0);
        @(posedge clk);
        #1 csr_we = 1'b0;
        #2 n_reset = 1'b1;
        rd(12'hC00, 32'd0, 1'b1);
        rd(12'hC02, 32'd0, 1'b1);
        rd(12'hC03, 32'd0, 1'b1);
        rd(12'h323, 32'd0, 1'b1);
        rd(12'h7C0, 32'd0, c_OVF);
        check("post_rst_ovf", {31'd0, ovf_irq}, 32'd0);

        repeat (3) tick();
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d reads outstanding expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
